branch_predictor: RTL
=====================

# branch_predictor

IF-stage branch prediction source for the pipelined RISC-V core: a direct-mapped branch target buffer (BTB) paired with a 2-bit saturating branch history table (BHT). Each cycle it produces the prediction fields that the ID-EX segment register carries forward: predicted next PC, BTB hit, fallback PC and BHT direction. When the branch resolves in EX, the block checks those carried fields, flags a misprediction with the corrected PC, and trains both tables. It also keeps branch and mispredict counters for performance measurement.

## Interface
- `ENTRIES`, 64: number of BTB and BHT entries; must be a power of two, minimum 4.
- `IDX_W`, $clog2(ENTRIES): index width; the index is `PC[IDX_W+1:2]`.
- `clk`  in  1  single core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `PCF`  in  32  fetch PC for lookup.
- `PPCF`  out  32  predicted next PC.
- `BTBF`  out  1  BTB hit (valid entry with tag match).
- `FPPCF`  out  32  fallback PC: the path not predicted.
- `BHTF`  out  1  BHT counter MSB (predicted direction).
- `UpdEnE`  in  1  a resolved conditional branch or jal is in EX; high for one cycle per instruction, already gated by stall/flush.
- `PCE`  in  32  PC of the resolved instruction.
- `BrTakenE`  in  1  actual direction.
- `BrTargetE`  in  32  actual taken target.
- `PPCE`  in  32  PPCF value carried through the ID-EX segment register.
- `MispredE`  out  1  misprediction flag for the instruction in EX.
- `CorrPCE`  out  32  correct next PC for redirect.
- `BrCnt`  out  32  number of resolved branches.
- `MissCnt`  out  32  number of mispredictions.

## Operation
- **Lookup (combinational from PCF):**
  - idx = PCF[IDX_W+1:2]; tag = PCF[31:IDX_W+2].
  - BTBF = valid[idx] && tag[idx]==tag.
  - BHTF = cnt[idx][1].
  - Predict taken iff BTBF && BHTF. If taken: PPCF = target[idx], FPPCF = PCF+4. Otherwise: PPCF = PCF+4, FPPCF = target[idx] on a hit, else PCF+4.
- **Resolve (combinational, valid only when UpdEnE=1):**
  - CorrPCE = BrTakenE ? BrTargetE : PCE+4.
  - MispredE = UpdEnE && (CorrPCE != PPCE).
  - When UpdEnE=0, MispredE=0 and CorrPCE = PCE+4.
- **Train (on the clock edge where UpdEnE=1), using the index and tag of PCE:**
  - BHT: increment the counter if BrTakenE, else decrement; saturate at 2'b11 and 2'b00.
  - BTB: if BrTakenE, write valid=1, the tag, and target=BrTargetE. This allocates or replaces the entry and refreshes a stale target.
  - BTB: if not taken, leave the entry untouched; the BHT alone steers direction.
  - Counters: BrCnt += 1; MissCnt += MispredE. Both wrap modulo 2^32.
- All PC arithmetic is 32-bit unsigned; the carry out of PC+4 is dropped.

## Timing
- Lookup latency is 0 cycles: the outputs settle combinationally from PCF.
- A training write becomes visible to lookups from the cycle after the edge that commits it.
- If a lookup and an update hit the same index in the same cycle, the lookup returns the pre-update contents.
- **Reset (rst_n low, asynchronous):**
  - All valid bits = 0.
  - All BHT counters = 2'b01 (weakly not-taken).
  - Targets and tags = 0.
  - BrCnt = MissCnt = 0.
- Immediately after reset: BTBF=0, BHTF=0, PPCF=FPPCF=PCF+4, MispredE=0 (while UpdEnE=0), CorrPCE=PCE+4.
- Reset asserted mid-operation discards any update sampled on that cycle. Deassertion is synchronized externally.
- Aliasing between PCs that share an index but differ in tag replaces the BTB entry and shares the BHT counter; this is by design.

## Structure
- Shared package `bp_pkg`:
  - typedef `bht_cnt_t` (2-bit).
  - constants `BHT_RESET=2'b01`, `BHT_MAX=2'b11`.
  - typedef `btb_entry_t` {valid, tag, target}.
- One sub-module, `bht_counter_table`: an ENTRIES×2-bit saturating counter array with a read port and an update port.
- BTB storage, resolve logic and the performance counters live in `branch_predictor`.
- Flop arrays only; no BRAM, since lookup must be same-cycle.

## Test plan
1. **Reset values:** hold rst_n=0, then release with PCF=0x100 -> BTBF=0, BHTF=0, PPCF=0x104, FPPCF=0x104, BrCnt=0, MissCnt=0.
2. **Cold miss then train:** pulse UpdEnE with PCE=0x100, BrTakenE=1, BrTargetE=0x80, PPCE=0x104 -> MispredE=1 and CorrPCE=0x80 that cycle; next cycle PCF=0x100 gives BTBF=1, BHTF=1 (counter 2'b10), PPCF=0x80, FPPCF=0x104; MissCnt=1.
3. **Saturation and direction flip:** four taken updates at 0x100 leave the counter at 2'b11. Then two not-taken updates -> counter 2'b01, BHTF=0, PPCF=0x104, FPPCF=0x80; a third not-taken update -> 2'b00 and stays there on a fourth.
4. **Same-cycle lookup and update:** PCF=PCE=0x200 with a taken update to 0x300 -> the same-cycle lookup shows BTBF=0; the next cycle shows PPCF=0x300.
5. **Tag alias:** with ENTRIES=64, train 0x100 taken to 0x80, then 0x200 taken to 0x40 (same index) -> PCF=0x100 gives BTBF=0; PCF=0x200 gives PPCF=0x40.
6. **Counter wrap and async reset:** force BrCnt to 0xFFFFFFFF and update once -> BrCnt=0. Assert rst_n low between clock edges -> every output returns to its reset value before the next edge.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the BTB/BHT branch predictor
package bp_pkg;
  localparam int TAG_W = 30;
  typedef logic [1:0] bht_cnt_t;
  localparam bht_cnt_t BHT_RESET = 2'b01;
  localparam bht_cnt_t BHT_MAX = 2'b11;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [31:0] target;
  } btb_entry_t;
endpackage

// File: rtl/bht_counter_table.sv
// bht_counter_table: ENTRIES x 2-bit saturating counters with one read and one update port
module bht_counter_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] ridx,
  output bht_cnt_t         rcnt,
  input  logic             upd,
  input  logic [IDX_W-1:0] widx,
  input  logic             taken
);
  bht_cnt_t cnt [ENTRIES];
  bht_cnt_t cur;
  assign rcnt = cnt[ridx];
  assign cur = cnt[widx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= BHT_RESET;
    else if (upd)
      cnt[widx] <= taken ? (cur == BHT_MAX ? cur : cur + 2'd1) : (cur == 2'b00 ? cur : cur - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB plus 2-bit BHT with EX-stage resolve, training and counters
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic [31:0] PPCF,
  output logic        BTBF,
  output logic [31:0] FPPCF,
  output logic        BHTF,
  input  logic        UpdEnE,
  input  logic [31:0] PCE,
  input  logic        BrTakenE,
  input  logic [31:0] BrTargetE,
  input  logic [31:0] PPCE,
  output logic        MispredE,
  output logic [31:0] CorrPCE,
  output logic [31:0] BrCnt,
  output logic [31:0] MissCnt
);
  btb_entry_t btb [ENTRIES];
  btb_entry_t fe;
  bht_cnt_t fcnt;
  logic [IDX_W-1:0] fidx, eidx;
  logic [TAG_W-1:0] ftag, etag;
  logic [31:0] pcf4, br_cnt, miss_cnt;
  logic unused_bits;
  assign unused_bits = ^{PCF[1:0], PCE[1:0]};
  assign fidx = PCF[IDX_W+1:2];
  assign eidx = PCE[IDX_W+1:2];
  assign ftag = TAG_W'(PCF >> (IDX_W + 2));
  assign etag = TAG_W'(PCE >> (IDX_W + 2));
  assign fe = btb[fidx];
  assign pcf4 = PCF + 32'd4;
  always_comb begin
    BTBF = fe.valid && fe.tag == ftag;
    BHTF = fcnt[1];
    PPCF = BTBF && BHTF ? fe.target : pcf4;
    FPPCF = BTBF && !BHTF ? fe.target : pcf4;
    CorrPCE = UpdEnE && BrTakenE ? BrTargetE : PCE + 32'd4;
    MispredE = UpdEnE && CorrPCE != PPCE;
  end
  bht_counter_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_bht (
    .clk(clk),
    .rst_n(rst_n),
    .ridx(fidx),
    .rcnt(fcnt),
    .upd(UpdEnE),
    .widx(eidx),
    .taken(BrTakenE)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
      br_cnt <= '0;
      miss_cnt <= '0;
    end else if (UpdEnE) begin
      br_cnt <= br_cnt + 32'd1;
      miss_cnt <= miss_cnt + 32'(MispredE);
      if (BrTakenE) btb[eidx] <= '{valid: 1'b1, tag: etag, target: BrTargetE};
    end
  assign BrCnt = br_cnt;
  assign MissCnt = miss_cnt;
endmodule
